boot_loader_seq: RTL and testbench

BOOT_LOADER_SEQ -- requirements
Module: boot_loader_seq

---
 rtl/boot_loader_seq_if.sv | 29 ++
 rtl/boot_loader_seq.sv | 150 +++++++++++++++
 tb/tb_boot_loader_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_seq_if.sv
// Bus bundle between the boot loader, its boot ROM and the core download port.
// The master side is the loader; the slave side is the ROM/core environment.
interface boot_loader_seq_if;
  logic        start;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        dn_go;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wait;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  modport master (
    input  start, rom_data, dn_wait,
    output rom_addr, dn_go, dn_wr, dn_addr, dn_data,
           execute_addr, execute_enable, busy, done, checksum
  );

  modport slave (
    output start, rom_data, dn_wait,
    input  rom_addr, dn_go, dn_wr, dn_addr, dn_data,
           execute_addr, execute_enable, busy, done, checksum
  );
endinterface

// File: rtl/boot_loader_seq.sv
// Copies ROM_LEN boot ROM bytes into the core through the download port at one
// byte per 2*CE_DIV clocks, then pulses execute_enable once.
module boot_loader_seq #(
  parameter int          ROM_LEN   = 276,
  parameter int          CE_DIV    = 16,
  parameter logic [15:0] EXEC_ADDR = 16'h0000
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  boot_loader_seq_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, EXEC, DONE} state_t;

  state_t      state_r, state_s;
  logic        start_q_r;
  logic [3:0]  cnt_r, cnt_s;
  logic [15:0] rom_addr_r, rom_addr_s;
  logic [15:0] dn_addr_r, dn_addr_s;
  logic [7:0]  dn_data_r, dn_data_s;
  logic [7:0]  checksum_r, checksum_s;
  logic        dn_go_r, dn_go_s;
  logic        dn_wr_r, dn_wr_s;
  logic        exe_r, exe_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        start_edge_s;
  logic        tick_s;
  logic        last_s;

  assign start_edge_s = bus.start & ~start_q_r;
  assign tick_s       = (cnt_r == 4'(CE_DIV - 1));
  // The terminal compare at ROM_LEN-1 keeps a 65536-byte copy from wrapping.
  assign last_s       = (rom_addr_r == 16'(ROM_LEN - 1));

  // Next-state and next-output logic for the copy sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rom_addr_s = rom_addr_r;
    dn_addr_s  = dn_addr_r;
    dn_data_s  = dn_data_r;
    checksum_s = checksum_r;
    dn_go_s    = dn_go_r;
    dn_wr_s    = dn_wr_r;
    exe_s      = 1'b0;
    busy_s     = busy_r;
    done_s     = done_r;

    if (busy_r) begin
      cnt_s = tick_s ? 4'd0 : (cnt_r + 4'd1);
    end else begin
      cnt_s = cnt_r;
    end

    case (state_r)
      IDLE, DONE: begin
        if (start_edge_s) begin
          state_s    = FETCH;
          cnt_s      = 4'd0;
          rom_addr_s = 16'd0;
          dn_addr_s  = 16'd0;
          checksum_s = 8'd0;
          dn_go_s    = 1'b1;
          busy_s     = 1'b1;
          done_s     = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      FETCH: begin
        if (tick_s && !bus.dn_wait) begin
          dn_data_s  = bus.rom_data;
          checksum_s = checksum_r + bus.rom_data;
          dn_wr_s    = 1'b1;
          state_s    = WRITE;
        end else begin
          state_s = FETCH;
        end
      end
      WRITE: begin
        if (tick_s) begin
          dn_wr_s = 1'b0;
          if (last_s) begin
            state_s = EXEC;
            exe_s   = 1'b1;
          end else begin
            rom_addr_s = rom_addr_r + 16'd1;
            dn_addr_s  = dn_addr_r + 16'd1;
            state_s    = FETCH;
          end
        end else begin
          state_s = WRITE;
        end
      end
      EXEC: begin
        dn_go_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, divider and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      start_q_r  <= 1'b0;
      cnt_r      <= 4'd0;
      rom_addr_r <= 16'd0;
      dn_addr_r  <= 16'd0;
      dn_data_r  <= 8'd0;
      checksum_r <= 8'd0;
      dn_go_r    <= 1'b0;
      dn_wr_r    <= 1'b0;
      exe_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      start_q_r  <= bus.start;
      cnt_r      <= cnt_s;
      rom_addr_r <= rom_addr_s;
      dn_addr_r  <= dn_addr_s;
      dn_data_r  <= dn_data_s;
      checksum_r <= checksum_s;
      dn_go_r    <= dn_go_s;
      dn_wr_r    <= dn_wr_s;
      exe_r      <= exe_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.rom_addr       = rom_addr_r;
  assign bus.dn_go          = dn_go_r;
  assign bus.dn_wr          = dn_wr_r;
  assign bus.dn_addr        = dn_addr_r;
  assign bus.dn_data        = dn_data_r;
  assign bus.execute_addr   = EXEC_ADDR;
  assign bus.execute_enable = exe_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.checksum       = checksum_r;

endmodule

// File: tb/tb_boot_loader_seq.sv
// Directed bench for boot_loader_seq: a write scoreboard fed by the stimulus and
// drained by a download-port monitor, plus timing checks on each copy.
module tb_boot_loader_seq;
  logic clk = 1'b0;
  logic reset_n;
  logic reset1_n;

  always #5 clk = ~clk;

  boot_loader_seq_if bus();
  boot_loader_seq_if bus1();

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] rom [4];
  wr_t        q[$];
  wr_t        q1[$];
  int         total = 0;
  int         bad = 0;
  int         exe_cnt = 0;
  int         exe1_cnt = 0;
  int         wr1_cnt = 0;
  int         rise_at[4];

  assign bus.rom_data  = rom[bus.rom_addr[1:0]];
  assign bus1.start    = 1'b1;
  assign bus1.dn_wait  = 1'b0;
  assign bus1.rom_data = (bus1.rom_addr == 16'h0000) ? 8'h11 : 8'h5A;

  boot_loader_seq #(.ROM_LEN(4), .CE_DIV(4), .EXEC_ADDR(16'hA5C3)) dut (
    .clk_sys(clk), .reset_n(reset_n), .bus(bus)
  );

  boot_loader_seq #(.ROM_LEN(1), .CE_DIV(4), .EXEC_ADDR(16'h0000)) dut1 (
    .clk_sys(clk), .reset_n(reset1_n), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Download-port monitor: scoreboard pop on each write, width and stability.
  initial begin : mon
    logic w_prev;
    int   w_width;
    logic [7:0] w_data;
    wr_t  e;
    w_prev  = 1'b0;
    w_width = 0;
    w_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        w_prev  = 1'b0;
        w_width = 0;
      end else begin
        if (bus.dn_wr && !w_prev) begin
          w_width = 1;
          w_data  = bus.dn_data;
          chk("sb_has_entry", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_addr", 32'(bus.dn_addr), 32'(e.a));
            chk("wr_data", 32'(bus.dn_data), 32'(e.d));
          end
        end else if (bus.dn_wr && w_prev) begin
          w_width++;
          chk("wr_data_stable", 32'(bus.dn_data), 32'(w_data));
        end else if (!bus.dn_wr && w_prev) begin
          chk("wr_width", 32'(w_width), 32'd4);
        end
        if (bus.execute_enable) begin
          exe_cnt++;
          chk("exe_after_last_wr", 32'(w_prev), 32'd1);
        end
        w_prev = bus.dn_wr;
      end
    end
  end

  // Monitor for the single-byte auto-boot instance.
  initial begin : mon1
    logic p;
    wr_t  e1;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset1_n) begin
        p = 1'b0;
      end else begin
        if (bus1.dn_wr && !p) begin
          wr1_cnt++;
          chk("rl1_sb_has_entry", 32'(q1.size() > 0), 32'd1);
          if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("rl1_wr_addr", 32'(bus1.dn_addr), 32'(e1.a));
            chk("rl1_wr_data", 32'(bus1.dn_data), 32'(e1.d));
          end
        end
        if (bus1.execute_enable) exe1_cnt++;
        p = bus1.dn_wr;
      end
    end
  end

  // One full copy from a start pulse; optional stall at byte 2 and a start
  // pulse during the copy. Cycle indices count negedges after the start edge.
  task automatic run_copy(input string tag, input int stall_at, input int restart_at,
                          input logic [7:0] exp_sum);
    int   i;
    int   nr;
    logic pw;
    int   exe_at;
    int   e0;
    int   extra;
    for (int k = 0; k < 4; k++) begin
      q.push_back({16'(k), rom[k]});
      rise_at[k] = -1;
    end
    extra  = (stall_at > 0) ? 8 : 0;
    e0     = exe_cnt;
    nr     = 0;
    pw     = 1'b0;
    exe_at = -1;
    i      = 0;
    @(negedge clk);
    bus.start = 1'b1;
    while (exe_at < 0 && i < 400) begin
      @(negedge clk);
      i++;
      if (i == 1) begin
        bus.start = 1'b0;
        chk({tag, "_busy_set"}, 32'(bus.busy), 32'd1);
        chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        chk({tag, "_dn_go_set"}, 32'(bus.dn_go), 32'd1);
      end
      if (stall_at > 0 && i == stall_at) bus.dn_wait = 1'b1;
      if (stall_at > 0 && i == stall_at + 10) bus.dn_wait = 1'b0;
      if (restart_at > 0 && i == restart_at) bus.start = 1'b1;
      if (restart_at > 0 && i == restart_at + 1) bus.start = 1'b0;
      if (bus.dn_wr && !pw) begin
        if (nr < 4) rise_at[nr] = i;
        nr++;
      end
      pw = bus.dn_wr;
      if (bus.execute_enable) exe_at = i;
    end
    bus.start   = 1'b0;
    bus.dn_wait = 1'b0;
    chk({tag, "_exe_at"}, 32'(exe_at), 32'(33 + extra));
    chk({tag, "_wr_count"}, 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_wr_rise"}, 32'(rise_at[k]), 32'(5 + 8 * k + ((k >= 2) ? extra : 0)));
    end
    repeat (2) @(negedge clk);
    chk({tag, "_checksum"}, 32'(bus.checksum), 32'(exp_sum));
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_dn_go"}, 32'(bus.dn_go), 32'd0);
    chk({tag, "_exe_low"}, 32'(bus.execute_enable), 32'd0);
    chk({tag, "_exe_pulses"}, 32'(exe_cnt - e0), 32'd1);
    chk({tag, "_sb_drained"}, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({tag, "_dn_go"}, 32'(bus.dn_go), 32'd0);
    chk({tag, "_dn_wr"}, 32'(bus.dn_wr), 32'd0);
    chk({tag, "_dn_addr"}, 32'(bus.dn_addr), 32'd0);
    chk({tag, "_dn_data"}, 32'(bus.dn_data), 32'd0);
    chk({tag, "_exec_addr"}, 32'(bus.execute_addr), 32'h0000A5C3);
    chk({tag, "_exe"}, 32'(bus.execute_enable), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_checksum"}, 32'(bus.checksum), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    reset1_n    = 1'b0;
    bus.start   = 1'b0;
    bus.dn_wait = 1'b0;
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
    q1.push_back({16'h0000, 8'h11});

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("rl1_reset_busy", 32'(bus1.busy), 32'd0);
    chk("rl1_reset_dn_go", 32'(bus1.dn_go), 32'd0);
    reset_n  = 1'b1;
    reset1_n = 1'b1;

    repeat (6) @(negedge clk);
    chk("no_auto_copy_busy", 32'(bus.busy), 32'd0);
    chk("no_auto_copy_done", 32'(bus.done), 32'd0);

    run_copy("normal", 0, 0, 8'hAA);
    run_copy("stall", 17, 0, 8'hAA);
    run_copy("restart_busy", 0, 10, 8'hAA);

    rom[0] = 8'hFF; rom[1] = 8'hFF; rom[2] = 8'h02; rom[3] = 8'h00;
    run_copy("sum_wrap", 0, 0, 8'h00);

    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
    run_copy("fresh", 0, 0, 8'hAA);

    // Reset during the byte-2 write strobe.
    for (int k = 0; k < 3; k++) q.push_back({16'(k), rom[k]});
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    chk("mid_wr_high", 32'(bus.dn_wr), 32'd1);
    chk("mid_wr_addr", 32'(bus.dn_addr), 32'd2);
    #1 reset_n = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);
    chk("post_reset_done", 32'(bus.done), 32'd0);
    chk("post_reset_dn_go", 32'(bus.dn_go), 32'd0);
    chk("post_reset_dn_wr", 32'(bus.dn_wr), 32'd0);
    chk("post_reset_sb", 32'(q.size()), 32'd0);

    chk("rl1_wr_count", 32'(wr1_cnt), 32'd1);
    chk("rl1_exe_count", 32'(exe1_cnt), 32'd1);
    chk("rl1_done", 32'(bus1.done), 32'd1);
    chk("rl1_busy", 32'(bus1.busy), 32'd0);
    chk("rl1_checksum", 32'(bus1.checksum), 32'h11);
    chk("rl1_sb_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
